md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage pipelined CPU.
- Consumes the MDControl/MDDataOp codes produced by the D-stage decoder and carried through the D/E pipeline register.
- Owns the HI/LO registers, models the multi-cycle latency of mult/div, and exports Busy/Start to the hazard unit so it can stall any MD-class instruction held in D.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start (1..15)
- DIV_CYCLES, 10, busy cycles after a div/divu start (1..15)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- E_MDControl  input  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi, 7 mfhi/mflo read, 8-15 no operation
- E_MDDataOp  input  4  read select when E_MDControl=7: 0 LO, 1 HI; other values read LO
- E_RsData  input  32  forwarded rs operand (multiplicand / dividend / mt source)
- E_RtData  input  32  forwarded rt operand (multiplier / divisor)
- E_Start  output  1  combinational: high when E_MDControl in 1..4 and E_Busy=0
- E_Busy  output  1  registered: high while a mult/div is in progress
- E_MDOut  output  32  combinational read data: HI or LO when E_MDControl=7, else 0

Behaviour:
- Reset, asynchronous and active-high, sets:
  - HI=0, LO=0, count=0, pending result=0
  - E_Busy=0
  - E_Start and E_MDOut then follow their combinational definitions.
- Start:
  - At the clock edge ending a cycle with E_Start=1, compute the result from the operands and hold it in hidden registers res_hi/res_lo.
  - Set count = MULT_CYCLES for codes 1/2, or DIV_CYCLES for codes 3/4.
  - HI/LO are not written at this edge.
- Busy:
  - E_Busy = (count != 0), registered.
  - count decrements by 1 each edge while nonzero.
  - On the edge where count goes from 1 to 0, HI <= res_hi and LO <= res_lo.
  - Result: E_Busy is high for exactly N cycles following the start cycle, and a read in cycle N+1 after start sees the new value.
- Arithmetic:
  - mult: signed 32x32, 64-bit product; HI = [63:32], LO = [31:0].
  - multu: unsigned, same split.
  - div: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned; LO = quotient, HI = remainder.
  - div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0 (div or divu): the operation still runs busy for DIV_CYCLES, but HI/LO are left unchanged at completion.
- mtlo/mthi:
  - Write E_RsData into LO/HI at the edge ending the cycle, only if E_Busy=0.
  - While busy the write is ignored. The hazard unit prevents this case; the bench flags it as an assertion failure.
- Read:
  - E_MDOut combinationally selects HI or LO.
  - While busy it returns the old values. The hazard unit guarantees no read is issued while E_Start|E_Busy.
- New mult/div code while E_Busy=1:
  - Ignored, with no restart and no state change.
  - Assertion failure in the bench, since the hazard unit must prevent it.
- Reset mid-operation: count cleared, pending result discarded, HI/LO forced to 0.
- Hazard-unit contract: stall D when the D instruction has MDControl != 0 and (E_Start | E_Busy).
- Codes 0 and 8-15: no state change, E_MDOut=0.

Test Plan:
- Signed mult: Rs=0xFFFFFFFF, Rt=0x00000002, code 1 at cycle 0.
  - Required: E_Start=1 in cycle 0; E_Busy=1 in cycles 1-5 and 0 in cycle 6.
  - mfhi (7/1) in cycle 6 reads 0xFFFFFFFF; mflo reads 0xFFFFFFFE.
- Unsigned mult: same operands, code 2.
  - Required: HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
  - A read in busy cycle 3 still returns the previous HI.
- Signed and unsigned div:
  - div Rs=0xFFFFFFF9 (-7), Rt=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF; E_Busy high for exactly 10 cycles.
  - divu 7/2: LO=3, HI=1.
  - div 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero and mt writes:
  - mthi 0x12345678, then mtlo 0x9ABCDEF0.
  - Then divu by 0: busy for 10 cycles, after which HI=0x12345678, LO=0x9ABCDEF0 (unchanged).
- Reset mid-operation: mult started, reset asserted asynchronously (mid-cycle) in busy cycle 3.
  - Required: E_Busy=0 immediately; HI=LO=0; no later write once reset is released.
- Back-to-back issue: mult then immediately mtlo 0x1 while E_Busy=1.
  - Required: mtlo ignored (assertion fires); mult result lands unaltered.
  - Then mtlo after E_Busy falls writes LO=0x1 at the next edge.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, models mult/div latency,
// and reports Start/Busy so the hazard unit can stall MD-class instructions.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDControl,
   input  logic [3:0]  E_MDDataOp,
   input  logic [31:0] E_RsData,
   input  logic [31:0] E_RtData,
   output logic        E_Start,
   output logic        E_Busy,
   output logic [31:0] E_MDOut
);

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTLO  = 4'd5,
      MD_MTHI  = 4'd6,
      MD_MFHL  = 4'd7
   } md_op_e;

   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] res_hi_q, res_hi_d;
   logic [31:0] res_lo_q, res_lo_d;
   logic        res_wr_q, res_wr_d;
   logic [3:0]  count_q, count_d;
   logic        busy_q, busy_d;

   logic [63:0] prod_s, prod_u;
   logic        div_signed;
   logic [31:0] abs_rs, abs_rt, div_den;
   logic [31:0] uq, ur, quo, rem;

   // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000
   // instead of overflowing; a zero divisor is replaced to keep the divider defined.
   always_comb begin
      prod_s     = {{32{E_RsData[31]}}, E_RsData} * {{32{E_RtData[31]}}, E_RtData};
      prod_u     = {32'b0, E_RsData} * {32'b0, E_RtData};
      div_signed = (E_MDControl == MD_DIV);
      abs_rs     = (div_signed && E_RsData[31]) ? -E_RsData : E_RsData;
      abs_rt     = (div_signed && E_RtData[31]) ? -E_RtData : E_RtData;
      div_den    = (E_RtData == '0) ? 32'd1 : abs_rt;
      uq         = abs_rs / div_den;
      ur         = abs_rs % div_den;
      quo        = (div_signed && (E_RsData[31] ^ E_RtData[31])) ? -uq : uq;
      rem        = (div_signed && E_RsData[31]) ? -ur : ur;
   end

   always_comb begin
      E_Start = (E_MDControl inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) && !busy_q;
      E_Busy  = busy_q;
      if (E_MDControl == MD_MFHL)
         E_MDOut = (E_MDDataOp == 4'd1) ? hi_q : lo_q;
      else
         E_MDOut = '0;
   end

   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      res_wr_d = res_wr_q;
      count_d  = count_q;
      if (count_q != '0) begin
         count_d = count_q - 4'd1;
         if (count_q == 4'd1 && res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
         end
      end else if (E_Start) begin
         if (E_MDControl == MD_MULT || E_MDControl == MD_MULTU) begin
            count_d  = 4'(MULT_CYCLES);
            res_wr_d = 1'b1;
            res_hi_d = (E_MDControl == MD_MULT) ? prod_s[63:32] : prod_u[63:32];
            res_lo_d = (E_MDControl == MD_MULT) ? prod_s[31:0]  : prod_u[31:0];
         end else begin
            count_d  = 4'(DIV_CYCLES);
            res_wr_d = (E_RtData != '0);
            res_hi_d = rem;
            res_lo_d = quo;
         end
      end else if (E_MDControl == MD_MTLO) begin
         lo_d = E_RsData;
      end else if (E_MDControl == MD_MTHI) begin
         hi_d = E_RsData;
      end
      busy_d = (count_d != '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q     <= '0;
         lo_q     <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         res_wr_q <= 1'b0;
         count_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         res_wr_q <= res_wr_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: cycle-numbered behavioural model checked every cycle,
// directed scenarios with literal expectations, then a random phase.
module tb_md_unit;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  E_MDControl;
   logic [3:0]  E_MDDataOp;
   logic [31:0] E_RsData;
   logic [31:0] E_RtData;
   logic        E_Start;
   logic        E_Busy;
   logic [31:0] E_MDOut;

   int checks = 0;
   int failures = 0;
   int viol = 0;

   md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .E_MDControl(E_MDControl), .E_MDDataOp(E_MDDataOp),
      .E_RsData(E_RsData), .E_RtData(E_RtData), .E_Start(E_Start), .E_Busy(E_Busy),
      .E_MDOut(E_MDOut)
   );

   always #5 clk = ~clk;

   // Model: HI/LO plus one pending result that commits at the end of cycle m_end.
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   logic        p_valid;
   logic        m_active;
   int          m_cyc, m_end;

   function automatic logic m_busy();
      return m_active && (m_cyc <= m_end);
   endfunction

   function automatic logic m_start();
      return (E_MDControl >= 4'd1 && E_MDControl <= 4'd4) && !m_busy();
   endfunction

   function automatic logic [31:0] m_out();
      if (E_MDControl != 4'd7) return 32'd0;
      return (E_MDDataOp == 4'd1) ? m_hi : m_lo;
   endfunction

   function automatic void m_compute(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l, output logic v);
      longint sa, sb, sp;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      v = 1'b1; h = '0; l = '0;
      case (c)
         4'd1: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
         4'd2: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
         4'd3: if (b == 0) v = 1'b0;
               else begin sp = sa / sb; l = sp[31:0]; sp = sa % sb; h = sp[31:0]; end
         default: if (b == 0) v = 1'b0;
               else begin up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0]; end
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_valid = 1'b0;
         m_active = 1'b0; m_cyc = 0; m_end = 0;
      end else begin
         logic b;
         b = m_busy();
         if (b && E_MDControl >= 4'd1 && E_MDControl <= 4'd6) begin
            viol++;
            $display("note: hazard contract breached, code %0d while busy at t=%0t", E_MDControl, $time);
         end
         if (b) begin
            if (m_cyc == m_end) begin
               if (p_valid) begin m_hi = p_hi; m_lo = p_lo; end
               m_active = 1'b0;
            end
         end else if (E_MDControl >= 4'd1 && E_MDControl <= 4'd4) begin
            m_compute(E_MDControl, E_RsData, E_RtData, p_hi, p_lo, p_valid);
            m_active = 1'b1;
            m_end = m_cyc + ((E_MDControl <= 4'd2) ? MULT_N : DIV_N);
         end else if (E_MDControl == 4'd5) begin
            m_lo = E_RsData;
         end else if (E_MDControl == 4'd6) begin
            m_hi = E_RsData;
         end
         m_cyc++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model_start", {31'b0, E_Start}, {31'b0, m_start()});
      chk("model_busy",  {31'b0, E_Busy},  {31'b0, m_busy()});
      chk("model_out",   E_MDOut, m_out());
   end

   // One cycle: drive after the rising edge, return just after the falling edge.
   task automatic go(input logic [3:0] c, input logic [3:0] d, input logic [31:0] rs, input logic [31:0] rt);
      @(posedge clk); #1;
      E_MDControl = c; E_MDDataOp = d; E_RsData = rs; E_RtData = rt;
      @(negedge clk); #1;
   endtask

   task automatic rd(input string name, input logic [3:0] d, input logic [31:0] exp);
      go(4'd7, d, '0, '0);
      chk(name, E_MDOut, exp);
   endtask

   task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] rs,
                         input logic [31:0] rt, input int n);
      int busy_n;
      go(c, 4'd0, rs, rt);
      chk({name, "_start"}, {31'b0, E_Start}, 32'd1);
      busy_n = 0;
      for (int i = 0; i < 20; i++) begin
         go(4'd0, 4'd0, '0, '0);
         if (E_Busy) busy_n++;
         else break;
      end
      chk({name, "_busy_len"}, busy_n, n);
   endtask

   initial begin
      reset = 1'b1;
      E_MDControl = '0; E_MDDataOp = '0; E_RsData = '0; E_RtData = '0;
      @(negedge clk); #1;
      chk("reset_busy", {31'b0, E_Busy}, 32'd0);
      E_MDControl = 4'd7; E_MDDataOp = 4'd1; #1;
      chk("reset_hi", E_MDOut, 32'd0);
      E_MDDataOp = 4'd0; #1;
      chk("reset_lo", E_MDOut, 32'd0);
      E_MDControl = 4'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // signed mult
      go(4'd1, 4'd0, 32'hFFFFFFFF, 32'h2);
      chk("mult_start", {31'b0, E_Start}, 32'd1);
      for (int i = 1; i <= 5; i++) begin
         go(4'd0, 4'd0, '0, '0);
         chk("mult_busy", {31'b0, E_Busy}, 32'd1);
      end
      go(4'd7, 4'd1, '0, '0);
      chk("mult_idle", {31'b0, E_Busy}, 32'd0);
      chk("mult_hi", E_MDOut, 32'hFFFFFFFF);
      rd("mult_lo", 4'd0, 32'hFFFFFFFE);

      // unsigned mult, read of old HI mid-flight
      go(4'd2, 4'd0, 32'hFFFFFFFF, 32'h2);
      go(4'd0, 4'd0, '0, '0);
      go(4'd0, 4'd0, '0, '0);
      rd("multu_old_hi", 4'd1, 32'hFFFFFFFF);
      go(4'd0, 4'd0, '0, '0);
      go(4'd0, 4'd0, '0, '0);
      rd("multu_hi", 4'd1, 32'h00000001);
      rd("multu_lo", 4'd0, 32'hFFFFFFFE);

      // divides
      run_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'h2, 10);
      rd("div_neg_lo", 4'd0, 32'hFFFFFFFD);
      rd("div_neg_hi", 4'd1, 32'hFFFFFFFF);
      run_op("divu", 4'd4, 32'd7, 32'd2, 10);
      rd("divu_lo", 4'd0, 32'd3);
      rd("divu_hi", 4'd1, 32'd1);
      run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10);
      rd("div_ovf_lo", 4'd0, 32'h80000000);
      rd("div_ovf_hi", 4'd1, 32'h0);

      // mt writes then divide by zero
      go(4'd6, 4'd0, 32'h12345678, '0);
      go(4'd5, 4'd0, 32'h9ABCDEF0, '0);
      run_op("divz", 4'd4, 32'd5, 32'd0, 10);
      rd("divz_hi", 4'd1, 32'h12345678);
      rd("divz_lo", 4'd0, 32'h9ABCDEF0);

      // asynchronous reset mid-operation
      go(4'd1, 4'd0, 32'd3, 32'd5);
      repeat (3) go(4'd0, 4'd0, '0, '0);
      reset = 1'b1; #1;
      chk("rst_mid_busy", {31'b0, E_Busy}, 32'd0);
      E_MDControl = 4'd7; E_MDDataOp = 4'd1; #1;
      chk("rst_mid_hi", E_MDOut, 32'd0);
      E_MDDataOp = 4'd0; #1;
      chk("rst_mid_lo", E_MDOut, 32'd0);
      E_MDControl = 4'd0;
      @(posedge clk); #1 reset = 1'b0;
      repeat (8) go(4'd0, 4'd0, '0, '0);
      rd("rst_after_hi", 4'd1, 32'd0);
      rd("rst_after_lo", 4'd0, 32'd0);

      // back-to-back issue while busy
      go(4'd1, 4'd0, 32'd6, 32'd7);
      go(4'd5, 4'd0, 32'd1, '0);
      go(4'd3, 4'd0, 32'd100, 32'd3);
      chk("b2b_no_start", {31'b0, E_Start}, 32'd0);
      repeat (3) go(4'd0, 4'd0, '0, '0);
      rd("b2b_lo", 4'd0, 32'd42);
      rd("b2b_hi", 4'd1, 32'd0);
      go(4'd5, 4'd0, 32'd1, '0);
      rd("b2b_mtlo", 4'd0, 32'd1);
      chk("contract_hits", viol, 2);

      // random phase obeying the hazard contract
      for (int n = 0; n < 600; n++) begin
         logic [3:0]  c;
         logic [31:0] rt;
         int unsigned r;
         @(posedge clk); #1;
         r = $urandom_range(0, 9);
         if (m_busy())
            c = (r < 3) ? 4'd7 : (r < 5) ? 4'd0 : 4'(8 + $urandom_range(0, 7));
         else
            c = (r < 6) ? 4'($urandom_range(1, 7)) : 4'($urandom_range(0, 15));
         case ($urandom_range(0, 5))
            0: rt = 32'd0;
            1: rt = $urandom_range(1, 9);
            2: rt = 32'hFFFFFFFF;
            default: rt = $urandom;
         endcase
         E_MDControl = c;
         E_MDDataOp = 4'($urandom_range(0, 3));
         E_RsData = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         E_RtData = rt;
         @(negedge clk); #1;
      end
      chk("contract_hits_final", viol, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
